mem_arbiter: RTL

Shares the single memory port between the frontend instruction-fetch requester (if_*) and the backend load/store requester (dm_*). It is a registered FSM that grants one requester at a time, holds the memory-side request stable until the memory answers, and returns read data with a one-cycle ack pulse. Data accesses normally win over fetch, but a bounded starvation counter guarantees fetch progress. It sits between frontend/backend and the memory model in the top-level.

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction-fetch requester (if_*)
//   and the load/store requester (dm_*). Registered three-state FSM
//   (IDLE, BUSY_IF, BUSY_DM): one requester is granted at a time, the
//   memory-side request is held stable until mem_rdy, and completion is
//   signalled with a one-cycle ack pulse plus registered read data.
//   Data accesses win by default; a saturating streak counter forces a
//   fetch grant after STARVE_MAX consecutive data grants with fetch waiting.
//
// Handshake: a requester raises x_req with its address/controls and keeps
//   them stable until x_ack pulses for one cycle. On the memory side,
//   mem_req and all mem_* controls stay constant while mem_req=1;
//   mem_rdy (with mem_rdata) completes the access and is ignored
//   whenever mem_req=0.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//   Adds a BUSY watchdog (parameter TIMEOUT). On expiry the pending
//   requester is acked together with a bus_err pulse and reads return 0.
//   Without the macro bus_err is constant 0 and BUSY waits indefinitely.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_rdata/if_ack           fetch data and completion pulse
//   dm_req/we/be/addr/wdata   data request and controls
//   dm_rdata/dm_ack           data read data and completion pulse
//   mem_req/we/be/addr/wdata  registered memory request
//   mem_rdata/mem_rdy         memory read data and completion
//   bus_err                   error pulse coincident with an ack
//   dbg_state                 current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_DM)

module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 255
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdy,
   output logic        bus_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

   state_t      state, state_nx;
   logic [3:0]  streak, streak_nx;
   logic        mem_req_nx, mem_we_nx;
   logic [3:0]  mem_be_nx;
   logic [31:0] mem_addr_nx, mem_wdata_nx;
   logic        if_ack_nx, dm_ack_nx;
   logic [31:0] if_rdata_nx, dm_rdata_nx;
   logic        if_elig, dm_elig, grant_dm, grant_if;
   logic        timeout_hit;

   // A requester whose ack is high this cycle is still presenting the
   // request it just completed, so it must not be granted again.
   assign if_elig  = if_req && !if_ack;
   assign dm_elig  = dm_req && !dm_ack;
   assign grant_dm = dm_elig && !(if_elig && (streak == STREAK_LIM));
   assign grant_if = if_elig && !grant_dm;

   assign dbg_state = state;

`ifdef MEM_ARB_TIMEOUT_EN
   // wd counts BUSY cycles already spent without mem_rdy; the timeout is
   // taken at the end of the TIMEOUT-th such cycle.
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [WD_W-1:0] wd, wd_nx;
   logic            bus_err_nx;

   assign timeout_hit = (state != IDLE) && !mem_rdy && (wd == WD_W'(TIMEOUT - 1));

   always_comb begin
      wd_nx      = wd;
      bus_err_nx = 1'b0;
      if (state == IDLE) begin
         wd_nx = '0;
      end else if (!mem_rdy) begin
         if (timeout_hit) bus_err_nx = 1'b1;
         else             wd_nx = wd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd      <= '0;
         bus_err <= 1'b0;
      end else begin
         wd      <= wd_nx;
         bus_err <= bus_err_nx;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;
`endif

   always_comb begin
      state_nx     = state;
      streak_nx    = streak;
      mem_req_nx   = mem_req;
      mem_we_nx    = mem_we;
      mem_be_nx    = mem_be;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      if_ack_nx    = 1'b0;
      dm_ack_nx    = 1'b0;
      if_rdata_nx  = if_rdata;
      dm_rdata_nx  = dm_rdata;
      case (state)
         IDLE: begin
            if (grant_dm) begin
               state_nx     = BUSY_DM;
               mem_req_nx   = 1'b1;
               mem_we_nx    = dm_we;
               mem_be_nx    = dm_be;
               mem_addr_nx  = dm_addr;
               mem_wdata_nx = dm_wdata;
               // Streak only builds while fetch is actually waiting.
               if (!if_req)                    streak_nx = 4'd0;
               else if (streak >= STREAK_LIM)  streak_nx = STREAK_LIM;
               else                            streak_nx = streak + 4'd1;
            end else if (grant_if) begin
               state_nx     = BUSY_IF;
               mem_req_nx   = 1'b1;
               mem_we_nx    = 1'b0;
               mem_be_nx    = 4'hF;
               mem_addr_nx  = if_addr;
               mem_wdata_nx = 32'd0;
               streak_nx    = 4'd0;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (mem_rdy || timeout_hit) begin
               state_nx   = IDLE;
               mem_req_nx = 1'b0;
               if (state == BUSY_IF) begin
                  if_ack_nx   = 1'b1;
                  if_rdata_nx = mem_rdy ? mem_rdata : 32'd0;
               end else begin
                  dm_ack_nx = 1'b1;
                  if (!mem_we) dm_rdata_nx = mem_rdy ? mem_rdata : 32'd0;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= 4'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'd0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         if_rdata  <= 32'd0;
         dm_rdata  <= 32'd0;
      end else begin
         state     <= state_nx;
         streak    <= streak_nx;
         mem_req   <= mem_req_nx;
         mem_we    <= mem_we_nx;
         mem_be    <= mem_be_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         if_ack    <= if_ack_nx;
         dm_ack    <= dm_ack_nx;
         if_rdata  <= if_rdata_nx;
         dm_rdata  <= dm_rdata_nx;
      end
   end

endmodule
